instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage that consumes the instruction pointer and returns instructions to the decoder. Drives the synchronous instruction memory from the current pointer value and advances the pointer only when a read was actually issued. Buffers returned words in a small FIFO with a valid/ready interface to the decoder. Discards everything in flight on a jump (flush).

Parameters:
ADDR_WIDTH, 8, instruction pointer / memory address width
INSTR_WIDTH, 32, instruction word width
DEPTH, 2, output FIFO entries (>=2; 2 sustains 1 instr/cycle)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ptr_in  in  ADDR_WIDTH  current (combinational) pointer value
ptr_enable  out  1  advance pointer this cycle (registered)
flush  in  1  jump taken this cycle; ptr_in already shows the target
mem_en  out  1  read strobe to instruction memory
mem_addr  out  ADDR_WIDTH  read address, equals ptr_in
mem_data  in  INSTR_WIDTH  read data, valid exactly 1 cycle after mem_en
instr_out  out  INSTR_WIDTH  instruction to decoder
instr_addr  out  ADDR_WIDTH  address of instr_out
instr_valid  out  1  instr_out valid
instr_ready  in  1  decoder accepts; pop = instr_valid & instr_ready

Behaviour:
- Reset (reset_n low, async): FIFO empty, inflight=0, ptr_enable=0, instr_valid=0, instr_out/instr_addr=0; mem_en forced 0 while reset_n low.
- Occupancy: occ = fifo_count + inflight. Issue condition: occ - pop < DEPTH. mem_en = issue; mem_addr = ptr_in always.
- On issue: inflight_q<=1, addr_q<=ptr_in; else inflight_q<=0.
- ptr_enable registered: ptr_enable<=issue. The pointer presents prev+1 only in the cycle after a read, so each issued address is consumed once.
- Return: when inflight_q=1 (and no flush this cycle), push {mem_data, addr_q} into FIFO. Push and pop in the same cycle are legal. The issue rule guarantees no push ever hits a full FIFO. Push-on-full is an assertion failure.
- Output: instr_out/instr_addr/instr_valid come from the FIFO head, first-word-fall-through. Latency from mem_en to instr_valid = 2 cycles when FIFO empty (1 mem + 1 FIFO write).
- Flush (cycle t): FIFO cleared, returning word at t dropped (inflight_q discarded), ptr_enable<=0.
  - Issue at t uses occ=0, so a read at the target address is issued in the same cycle and is kept.
  - A pop at t still completes; instr_valid=0 from t+1 until the target word arrives at t+2.
- Flush on consecutive cycles: each one restarts at its own target. Only the last target's word survives.
- Back-pressure: instr_ready=0 fills FIFO to DEPTH, then mem_en=0 and ptr_enable=0 one cycle later. The pointer holds and no address is skipped or duplicated.
- Wrap-around: addresses wrap at 2^ADDR_WIDTH, inherited from the pointer. No special handling.
- Reset mid-operation clears all state regardless of outstanding reads. A mem_data word arriving after reset is ignored (inflight=0).

Decomposition:
- Shared package: ADDR_WIDTH/INSTR_WIDTH defaults, memory read latency constant (1).
- Sub-module fetch_fifo: sync FIFO, width ADDR_WIDTH+INSTR_WIDTH, depth DEPTH, ports push/pop/clear/count/full/empty, async active-low reset, FWFT head. instr_fetch holds only the issue/inflight/ptr_enable logic.

Test Plan:
- Streaming: release reset with ptr_in=0 and ideal memory (data=addr*3), instr_ready=1 -> first mem_en in cycle 0 after release. instr_valid from cycle 2, then instr_addr 0,1,2,... one per cycle with instr_out 0,3,6,...; ptr_enable=1 from cycle 1.
- Back-pressure: instr_ready=0 at addr 4 for 5 cycles -> FIFO holds 4,5. mem_en/ptr_enable low after the fill, pointer holds at 6. On release the output is 4,5,6,7 with no gap, skip or duplicate.
- Flush: jump to 0x40 while 0x10 is in flight and 0x0F is buffered -> 0x0F and 0x10 never appear. instr_valid=0 for one cycle, then instr_addr=0x40, 0x41.
- Flush with pop: flush in the same cycle instr_ready pops 0x0F -> 0x0F counted as accepted once. Next valid output is the target.
- Back-to-back flushes to 0x20 then 0x30 -> only 0x30 onwards is emitted.
- Async reset mid-stream: reset_n low between clock edges -> instr_valid, ptr_enable and mem_en drop immediately. After release, fetch restarts at ptr_in=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths and
// the read latency of the synchronous instruction memory.
package instr_fetch_pkg;

    localparam int ADDR_WIDTH_DEF   = 8;
    localparam int INSTR_WIDTH_DEF  = 32;
    localparam int DEPTH_DEF        = 2;
    localparam int MEM_READ_LATENCY = 1;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, used to buffer
// returned instruction words ({data, addr}) in front of the decoder.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = ADDR_WIDTH_DEF + INSTR_WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CNT_WIDTH = count_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [IDX_W-1:0]     rd_ptr_r;
    logic [IDX_W-1:0]     wr_ptr_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    // Circular index advance that also works for non-power-of-two depths.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(DEPTH - 1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    assign count = count_r;
    assign empty = (count_r == {CNT_WIDTH{1'b0}});
    assign full  = (count_r == CNT_WIDTH'(DEPTH));

    // Qualify requests; a write into a full buffer is dropped rather than corrupting state.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Head word is zero whenever nothing valid is buffered.
    always_comb begin
        if (empty) begin
            head = {WIDTH{1'b0}};
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the buffer in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= {IDX_W{1'b0}};
            wr_ptr_r <= {IDX_W{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {IDX_W{1'b0}};
            wr_ptr_r <= {IDX_W{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= next_idx(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_idx(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_WIDTH'(1);
                2'b01:   count_r <= count_r - CNT_WIDTH'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_fifo_checker.sv
// Protocol checker for the fetch output buffer: a write must never land on a
// full buffer, because the issue rule reserves a slot for every read issued.
module fetch_fifo_checker (
    input logic clk,
    input logic reset_n,
    input logic push,
    input logic full
);

    push_on_full_a: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues reads to the synchronous instruction memory at the
// current pointer, requests a pointer advance only after a read was issued,
// and buffers returned words for the decoder. A flush drops everything in
// flight and restarts at the jump target.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_WIDTH-1:0]  ptr_in,
    output logic                   ptr_enable,
    input  logic                   flush,
    output logic                   mem_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    localparam int CNT_WIDTH = count_width(DEPTH);
    localparam int OCC_WIDTH = CNT_WIDTH + 1;
    localparam int ENTRY_W   = INSTR_WIDTH + ADDR_WIDTH;

    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [CNT_WIDTH-1:0]  fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [ENTRY_W-1:0]    fifo_head_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [OCC_WIDTH-1:0]  occ_s;
    logic [OCC_WIDTH-1:0]  limit_s;

    // Issue a read whenever the buffer plus the outstanding read leaves room
    // after this cycle's pop; a flush empties everything so it always issues.
    always_comb begin
        pop_s   = !fifo_empty_s && instr_ready;
        push_s  = inflight_r && !flush;
        occ_s   = OCC_WIDTH'(fifo_count_s) + OCC_WIDTH'(inflight_r);
        limit_s = OCC_WIDTH'(DEPTH) + OCC_WIDTH'(pop_s);
        if (flush) begin
            issue_s = 1'b1;
        end else begin
            issue_s = (occ_s < limit_s);
        end
    end

    assign mem_en      = issue_s && reset_n;
    assign mem_addr    = ptr_in;
    assign instr_valid = !fifo_empty_s;
    assign instr_out   = fifo_head_s[ENTRY_W-1:ADDR_WIDTH];
    assign instr_addr  = fifo_head_s[ADDR_WIDTH-1:0];

    // Track the single outstanding memory read and request the pointer advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            ptr_enable <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            addr_r     <= ptr_in;
            ptr_enable <= flush ? 1'b0 : issue_s;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (push_s),
        .push_data ({mem_data, addr_r}),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    fetch_fifo_checker u_fifo_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .full    (fifo_full_s)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. The environment models the pointer
// unit (ptr_in = ptr + ptr_enable; a jump presents the target and the
// pointer then continues from target+1) and an ideal memory returning addr*3.
// A queue-level reference model predicts every output each cycle.
module tb_instr_fetch;

    localparam int AW    = 8;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] ptr_in = '0;
    logic          flush = 1'b0;
    logic [IW-1:0] mem_data = '0;
    logic          instr_ready = 1'b0;
    logic          ptr_enable;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_addr;
    logic          instr_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [AW-1:0] m_q[$];
    bit            m_infl = 1'b0;
    logic [AW-1:0] m_infl_addr = '0;
    bit            m_pen = 1'b0;
    logic [AW-1:0] m_ptr = '0;

    typedef struct {
        bit            rdy;
        bit            e_mem_en;
        logic [AW-1:0] e_mem_addr;
        bit            e_pen;
        bit            e_valid;
        logic [AW-1:0] e_addr;
        logic [IW-1:0] e_out;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ptr_in      (ptr_in),
        .ptr_enable  (ptr_enable),
        .flush       (flush),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .instr_out   (instr_out),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return IW'(a) * 32'd3;
    endfunction

    // Ideal synchronous memory: one cycle read latency
    always @(posedge clk) begin
        if (mem_en) mem_data <= mem_word(mem_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_infl = 1'b0;
        m_infl_addr = '0;
        m_pen = 1'b0;
        m_ptr = '0;
    endtask

    // Drive one cycle's inputs (called just after a falling edge), compare
    // against the model, and advance the model to the next cycle.
    task automatic apply(input bit fl, input logic [AW-1:0] tgt, input bit rdy);
        bit e_valid, e_pop, e_issue;
        logic [AW-1:0] e_ptr;
        e_ptr = fl ? tgt : m_ptr + AW'(m_pen);
        flush = fl;
        ptr_in = e_ptr;
        instr_ready = rdy;
        #1;
        e_valid = (m_q.size() > 0);
        e_pop   = e_valid && rdy;
        e_issue = fl || ((m_q.size() + int'(m_infl) - int'(e_pop)) < DEPTH);
        check("mem_en", 64'(mem_en), 64'(e_issue));
        check("mem_addr", 64'(mem_addr), 64'(e_ptr));
        check("ptr_enable", 64'(ptr_enable), 64'(m_pen));
        check("instr_valid", 64'(instr_valid), 64'(e_valid));
        if (e_valid) begin
            check("instr_addr", 64'(instr_addr), 64'(m_q[0]));
            check("instr_out", 64'(instr_out), 64'(mem_word(m_q[0])));
        end
        if (fl) begin
            m_q.delete();
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_addr);
        end
        m_infl      = e_issue;
        m_infl_addr = e_ptr;
        m_pen       = fl ? 1'b0 : e_issue;
        m_ptr       = fl ? tgt + AW'(1) : e_ptr;
    endtask

    task automatic cycle(input bit fl, input logic [AW-1:0] tgt, input bit rdy);
        apply(fl, tgt, rdy);
        @(negedge clk);
    endtask

    initial begin
        // Streaming start with a back-pressure window at address 2
        //            rdy   mem_en addr   pen   valid  iaddr  iout
        vecs[0] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 8'd0, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 8'd2, 1'b1, 1'b1, 8'd0, 32'd0};
        vecs[3] = '{1'b1, 1'b1, 8'd3, 1'b1, 1'b1, 8'd1, 32'd3};
        vecs[4] = '{1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 8'd2, 32'd6};
        vecs[5] = '{1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 8'd2, 32'd6};
        vecs[6] = '{1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 8'd2, 32'd6};
        vecs[7] = '{1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 8'd3, 32'd9};
        vecs[8] = '{1'b1, 1'b1, 8'd6, 1'b1, 1'b1, 8'd4, 32'd12};

        // Reset state
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr_out", 64'(instr_out), 64'd0);
        check("rst_instr_addr", 64'(instr_addr), 64'd0);
        check("rst_ptr_enable", 64'(ptr_enable), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven streaming and back-pressure
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 8'd0, vecs[i].rdy);
            check("tbl_mem_en", 64'(mem_en), 64'(vecs[i].e_mem_en));
            check("tbl_mem_addr", 64'(mem_addr), 64'(vecs[i].e_mem_addr));
            check("tbl_ptr_enable", 64'(ptr_enable), 64'(vecs[i].e_pen));
            check("tbl_instr_valid", 64'(instr_valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check("tbl_instr_addr", 64'(instr_addr), 64'(vecs[i].e_addr));
                check("tbl_instr_out", 64'(instr_out), 64'(vecs[i].e_out));
            end
            @(negedge clk);
        end

        // Flush while 0x0F is buffered and 0x10 in flight, decoder stalled
        cycle(1'b1, 8'h0C, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        apply(1'b1, 8'h40, 1'b0);
        check("pre_flush_head", 64'(instr_addr), 64'h0F);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("flush_gap_valid", 64'(instr_valid), 64'd0);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("flush_tgt_valid", 64'(instr_valid), 64'd1);
        check("flush_tgt_addr", 64'(instr_addr), 64'h40);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("flush_tgt_next", 64'(instr_addr), 64'h41);
        @(negedge clk);

        // Flush in the same cycle the decoder pops 0x0F
        cycle(1'b1, 8'h0C, 1'b1);
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        apply(1'b1, 8'h50, 1'b1);
        check("popflush_head_valid", 64'(instr_valid), 64'd1);
        check("popflush_head_addr", 64'(instr_addr), 64'h0F);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("popflush_gap", 64'(instr_valid), 64'd0);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("popflush_tgt", 64'(instr_addr), 64'h50);
        @(negedge clk);

        // Back-to-back flushes: only the last target survives
        repeat (3) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h20, 1'b1);
        apply(1'b1, 8'h30, 1'b1);
        check("b2b_valid_t1", 64'(instr_valid), 64'd0);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("b2b_valid_t2", 64'(instr_valid), 64'd0);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("b2b_tgt_addr", 64'(instr_addr), 64'h30);
        @(negedge clk);
        apply(1'b0, 8'h00, 1'b1);
        check("b2b_tgt_next", 64'(instr_addr), 64'h31);
        @(negedge clk);

        // Wrap-around through the top of the address space
        cycle(1'b1, 8'hFD, 1'b1);
        repeat (7) cycle(1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit fl, rdy;
            logic [AW-1:0] tgt;
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = AW'($urandom);
            cycle(fl, tgt, rdy);
        end

        // Async reset mid-stream
        repeat (4) cycle(1'b0, 8'h00, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_instr_valid", 64'(instr_valid), 64'd0);
        check("arst_ptr_enable", 64'(ptr_enable), 64'd0);
        check("arst_mem_en", 64'(mem_en), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        apply(1'b0, 8'h00, 1'b1);
        check("restart_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        repeat (6) cycle(1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
